// File: rtl/alu_frame_ctrl.sv
// Frame sequencer for the 8-bit ALU. Collects A, B and opcode bytes, drives registered operands
// to the core, and captures the result and flags behind a valid/ready output port.
module alu_frame_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_r,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_c,
  input  logic       alu_v,
  output logic [7:0] out_data,
  output logic [4:0] out_flags,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] frame_cnt
);

  typedef enum logic [2:0] {
    StGetA,
    StGetB,
    StGetOp,
    StExec,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic [4:0] flags_q, flags_d;
  logic       valid_q, valid_d;
  logic [7:0] cnt_q, cnt_d;

  logic in_xfer;
  logic out_xfer;
  logic err;

  // Ready is decoded from state only, so there is no input-to-output path.
  assign in_ready = (state_q == StGetA) || (state_q == StGetB) || (state_q == StGetOp);
  assign in_xfer  = in_valid & in_ready & ena;
  assign out_xfer = valid_q & out_ready & ena;
  assign err      = (op_q == 3'b110) || (op_q == 3'b111);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    data_d  = data_q;
    flags_d = flags_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StGetA: begin
        if (in_xfer) begin
          a_d     = in_data;
          state_d = StGetB;
        end
      end
      StGetB: begin
        if (in_xfer) begin
          b_d     = in_data;
          state_d = StGetOp;
        end
      end
      StGetOp: begin
        if (in_xfer) begin
          op_d    = in_data[2:0];
          state_d = StExec;
        end
      end
      StExec: begin
        if (ena) begin
          data_d  = alu_r;
          flags_d = {err, alu_v, alu_c, alu_n, alu_z};
          valid_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_xfer) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          state_d = StGetA;
        end
      end
      default: state_d = StGetA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StGetA;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      op_q    <= 3'b000;
      data_q  <= 8'h00;
      flags_q <= 5'b00000;
      valid_q <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign out_data  = data_q;
  assign out_flags = flags_q;
  assign out_valid = valid_q;
  assign frame_cnt = cnt_q;

endmodule

// File: doc/alu_frame_ctrl.md
# alu_frame_ctrl

Sequencing front-end for the 8-bit ALU datapath. It collects a three-byte command frame (operand A, operand B, opcode) from the shared 8-bit input bus and drives registered operands to the combinational ALU core. It captures the ALU result and flags one cycle later and holds them on a valid/ready output port until consumed. It sits between the chip-level I/O pins and the ALU core, feeding the core's A/B/op inputs and consuming its R/Zero/Negative/Carry/Overflow outputs.

## Interface
- No parameters; all widths fixed: data 8 bits, opcode 3 bits.
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  clock enable; when 0 all registers hold and handshakes stall (in_ready, out_valid keep their values, but no transfer occurs).
- in_data  in  8  frame byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts a byte this cycle.
- alu_a  out  8  registered operand A to the ALU core.
- alu_b  out  8  registered operand B to the ALU core.
- alu_op  out  3  registered opcode to the ALU core.
- alu_r  in  8  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_z, alu_n, alu_c, alu_v  in  1 each  ALU Zero/Negative/Carry/Overflow.
- out_data  out  8  captured result.
- out_flags  out  5  {err, V, C, N, Z} captured with out_data.
- out_valid  out  1  out_data/out_flags hold a result.
- out_ready  in  1  consumer accepts result.
- frame_cnt  out  8  count of completed result transfers, wraps 255->0.

## Operation
- States: GET_A, GET_B, GET_OP, EXEC, DONE. Reset state GET_A.
- Byte transfer = in_valid & in_ready & ena on a rising edge. in_ready = 1 exactly in GET_A, GET_B, GET_OP.
- GET_A: on transfer, alu_a <= in_data; -> GET_B.
- GET_B: on transfer, alu_b <= in_data; -> GET_OP.
- GET_OP: on transfer, alu_op <= in_data[2:0]; in_data[7:3] ignored; -> EXEC.
- EXEC (one cycle, ena=1): out_data <= alu_r; out_flags <= {err, alu_v, alu_c, alu_n, alu_z}; out_valid <= 1; -> DONE.
- err = 1 when alu_op is 3'b110 or 3'b111 (reserved). Result and flags are still captured as driven by the core (R = 0, Z = 1).
- DONE: out_valid = 1. Result transfer = out_valid & out_ready & ena on a rising edge. On transfer: out_valid <= 0, frame_cnt <= frame_cnt + 1 (mod 256), -> GET_A.
- alu_a/alu_b/alu_op change only on their own byte transfer. They are stable from EXEC through DONE; between frames they keep their last values.
- out_data/out_flags change only in EXEC; they hold their value after transfer until the next EXEC.
- in_valid in EXEC/DONE is ignored (in_ready = 0); no byte is lost or queued.
- ena = 0 in any state: no state, register or counter change, including in EXEC. EXEC resumes on the first cycle with ena = 1.
- No frame abort other than reset. A partial frame waits indefinitely in GET_B/GET_OP.

## Timing
- Reset values: state GET_A, alu_a 0, alu_b 0, alu_op 0, out_data 0, out_flags 0, out_valid 0, frame_cnt 0. in_ready = 1 immediately after reset deasserts.
- Reset asserted mid-frame or in DONE: everything returns to the reset values asynchronously. A pending result is discarded and frame_cnt is not incremented.
- Latency: opcode transfer at edge k; EXEC during cycle k..k+1; out_valid high after edge k+1. A same-cycle out_ready completes the transfer at edge k+2.
- Minimum frame period with in_valid and out_ready tied high: 5 cycles (3 bytes, EXEC, DONE).
- First byte of the next frame can transfer at the edge after the result transfer (in_ready rises in the same cycle out_valid falls).
- All outputs are registered or decoded from state only; there is no combinational path from in_* or out_ready to any output.

## Test plan
- Reset then frame 0x05, 0x03, 0x00 (add), out_ready = 1 -> out_valid 2 cycles after opcode byte; out_data 0x08, out_flags 5'b00000, frame_cnt 1.
- Frame 0x80, 0x80, 0x00 -> out_data 0x00, flags err0 V1 C1 N0 Z1. Then frame 0x03, 0x05, 0x01 (sub) -> out_data 0xFE, N1 C0 Z0.
- Reserved op 0x07 with A=0x12, B=0x34 -> out_data 0x00, out_flags 5'b10001. Upper opcode bits set (0xFA) -> op 3'b010, out_data = A & B.
- Backpressure: out_ready = 0 for 10 cycles in DONE while in_valid = 1 with varying in_data -> in_ready 0, out_data stable, alu_a unchanged. Raise out_ready -> one transfer, frame_cnt +1.
- ena toggling every other cycle through a full frame -> same result as with ena = 1, with exactly double cycle count. Reset asserted in GET_OP -> all outputs 0, in_ready 1, frame_cnt 0.
- 256 back-to-back frames with in_valid/out_ready high -> 5-cycle period; frame_cnt wraps to 0.
